// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer so in_ready comes from state only.
// Inserts NOP bubbles when empty, reports occupancy and keeps a saturating flush count.
module pipe_stage_skid #(
   parameter int unsigned        DATA_W    = 64,
   parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
   parameter int unsigned        CNT_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [1:0]        occupancy,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept, advance;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;
   assign flush_cnt = cnt_q;

   assign accept  = in_valid & in_ready;
   assign advance = out_valid & out_ready & ~stall;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Squash drops everything, including a beat accepted this cycle.
         state_d = EMPTY;
         main_d  = NOP_VALUE;
         skid_d  = NOP_VALUE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (accept && advance) begin
                  main_d = in_data;
               end else if (accept) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (advance) begin
                  state_d = EMPTY;
                  main_d  = NOP_VALUE;
               end
            end
            FULL: begin
               if (advance) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = NOP_VALUE;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = NOP_VALUE;
               skid_d  = NOP_VALUE;
            end
         endcase
      end
   end

   // Clear wins over a same-cycle flush increment; the count sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (flush && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= EMPTY;
         main_q  <= NOP_VALUE;
         skid_q  <= NOP_VALUE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: accepted beats feed a queue, a monitor pops and
// compares every beat the stage hands downstream; directed checks cover state outputs.
module tb_pipe_stage_skid;

   localparam int unsigned       DATA_W = 16;
   localparam logic [DATA_W-1:0] NOP    = 16'h00E0;
   localparam int unsigned       CNT_W  = 2;

   logic              clk = 1'b0;
   logic              reset, flush, stall, in_valid, out_ready, cnt_clr;
   logic [DATA_W-1:0] in_data;
   logic              in_ready, out_valid;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  flush_cnt;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_q[$];

   pipe_stage_skid #(
      .DATA_W   (DATA_W),
      .NOP_VALUE(NOP),
      .CNT_W    (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .stall    (stall),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready),
      .occupancy(occupancy),
      .cnt_clr  (cnt_clr),
      .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard feed: every beat the stage will take at the coming edge.
   always @(negedge clk) begin
      if (!reset || flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
   end

   // Monitor: every beat handed downstream at the coming edge must match the queue head.
   always @(negedge clk) begin
      if (reset && !flush) begin
         if (out_valid && out_ready && !stall) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_beat: got %0h, expected no beat", out_data);
            end else begin
               chk("out_beat", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
         end
         if (!out_valid) chk("bubble_nop", {16'h0, out_data}, {16'h0, NOP});
      end
   end

   initial begin
      reset = 1'b0; flush = 1'b0; stall = 1'b0; cnt_clr = 1'b0;
      in_valid = 1'b1; in_data = 16'h00AA; out_ready = 1'b1;

      // Reset held two cycles with a valid beat offered
      repeat (2) step();
      chk("rst_out_valid", {31'h0, out_valid}, 0);
      chk("rst_out_data",  {16'h0, out_data}, {16'h0, NOP});
      chk("rst_in_ready",  {31'h0, in_ready}, 1);
      chk("rst_occupancy", {30'h0, occupancy}, 0);
      chk("rst_flush_cnt", {30'h0, flush_cnt}, 0);
      reset = 1'b1; in_valid = 1'b0;
      step();
      chk("rel_occupancy", {30'h0, occupancy}, 0);

      // Streaming 1..4 at full rate
      in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_data = DATA_W'(i);
         step();
         chk("stream_data",  {16'h0, out_data}, i);
         chk("stream_occ",   {30'h0, occupancy}, 1);
         chk("stream_ready", {31'h0, in_ready}, 1);
      end
      in_valid = 1'b0;
      step();
      chk("stream_drain_occ", {30'h0, occupancy}, 0);
      chk("stream_drain_vld", {31'h0, out_valid}, 0);

      // Backpressure into skid
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd5;
      step();
      chk("bp_occ1",   {30'h0, occupancy}, 1);
      chk("bp_rdy1",   {31'h0, in_ready}, 1);
      in_data = 16'd6;
      step();
      chk("bp_occ2",   {30'h0, occupancy}, 2);
      chk("bp_rdy0",   {31'h0, in_ready}, 0);
      chk("bp_head5",  {16'h0, out_data}, 5);
      in_data = 16'd7;
      step();
      chk("bp_hold_occ", {30'h0, occupancy}, 2);
      chk("bp_hold_5",   {16'h0, out_data}, 5);
      out_ready = 1'b1;
      step();
      chk("bp_out6",   {16'h0, out_data}, 6);
      chk("bp_occ_1",  {30'h0, occupancy}, 1);
      step();
      chk("bp_out7",   {16'h0, out_data}, 7);
      in_valid = 1'b0;
      step();
      chk("bp_empty",  {30'h0, occupancy}, 0);

      // Flush beats stall with the stage full
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd8;
      step();
      in_data = 16'd9;
      step();
      chk("sf_full", {30'h0, occupancy}, 2);
      stall = 1'b1; flush = 1'b1; in_data = 16'h0055;
      step();
      chk("sf_vld",  {31'h0, out_valid}, 0);
      chk("sf_data", {16'h0, out_data}, {16'h0, NOP});
      chk("sf_occ",  {30'h0, occupancy}, 0);
      chk("sf_cnt",  {30'h0, flush_cnt}, 1);
      stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("sf_still_empty", {30'h0, occupancy}, 0);

      // Stall holds a single beat with out_ready high
      in_valid = 1'b1; in_data = 16'h0010;
      step();
      in_valid = 1'b0; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_data", {16'h0, out_data}, 32'h10);
         chk("stall_vld",  {31'h0, out_valid}, 1);
      end
      stall = 1'b0;
      step();
      chk("stall_drain", {31'h0, out_valid}, 0);

      // Saturating flush counter, and flush squashing a same-cycle accept
      cnt_clr = 1'b1;
      step();
      chk("cnt_clr0", {30'h0, flush_cnt}, 0);
      cnt_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0020;
      step();
      chk("cnt_load_occ", {30'h0, occupancy}, 1);
      flush = 1'b1; in_data = 16'h0021;
      step();
      chk("cnt_1",     {30'h0, flush_cnt}, 1);
      chk("cnt_f_occ", {30'h0, occupancy}, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("cnt_sat", {30'h0, flush_cnt}, (i == 0) ? 2 : 3);
      end
      cnt_clr = 1'b1;
      step();
      chk("cnt_clr_wins", {30'h0, flush_cnt}, 0);
      cnt_clr = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("squash_occ", {30'h0, occupancy}, 0);
      chk("squash_vld", {31'h0, out_valid}, 0);

      repeat (3) step();
      chk("sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish, expected finish before 20000");
      $fatal(1);
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register, the successor to the fixed IF/ID latch.
- Carries a DATA_W-bit payload (e.g. {PC, Instruction}) between two stages using a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered-path only, so upstream stalls do not form a combinational chain.
- Keeps the existing priority: reset > flush > stall. Adds bubble (NOP) insertion on empty, an occupancy output, and a saturating flush counter.

Parameters:
- DATA_W, 64, payload width in bits.
- NOP_VALUE, 0, payload value driven on out_data whenever out_valid=0 and loaded on flush.
- CNT_W, 8, width of the flush event counter.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- flush  in  1  discard all held entries (branch/jump squash).
- stall  in  1  hazard hold; output side treated as not ready.
- in_valid  in  1  upstream payload valid.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept this cycle.
- out_valid  out  1  out_data holds a real payload.
- out_data  out  DATA_W  payload to the next stage.
- out_ready  in  1  downstream accepts this cycle.
- occupancy  out  2  entries held (0..2).
- cnt_clr  in  1  synchronous clear of flush_cnt.
- flush_cnt  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Storage: main register (drives out_data), skid register, 2-bit state EMPTY(0) / ONE(1) / FULL(2). occupancy = state encoding.
- Derived signals, all from state only (no input-to-output combinational path except via the advance term in the state update):
  - in_ready = (state != FULL)
  - out_valid = (state != EMPTY)
  - accept = in_valid & in_ready
  - advance = out_valid & out_ready & ~stall
- Reset (reset=0 at edge): state=EMPTY, main=skid=NOP_VALUE, flush_cnt=0. Resulting outputs: out_valid=0, out_data=NOP_VALUE, in_ready=1, occupancy=0. All inputs are ignored while reset=0. Asserting reset mid-transfer drops held data with no partial output.
- Flush (reset=1, flush=1): state→EMPTY, main=skid=NOP_VALUE, and any same-cycle accept is discarded. Flush overrides stall, out_ready and in_valid. flush_cnt increments unless it is all-ones.
- cnt_clr=1: flush_cnt→0, taking priority over a same-cycle flush increment.
- Normal operation (reset=1, flush=0), transitions at the clock edge:
  - EMPTY: accept → ONE, main←in_data. Otherwise hold.
  - ONE, accept & advance: stay ONE, main←in_data (back-to-back streaming, throughput 1/cycle).
  - ONE, accept & ~advance: → FULL, skid←in_data, main unchanged.
  - ONE, ~accept & advance: → EMPTY, main←NOP_VALUE.
  - ONE, neither: hold.
  - FULL, advance: → ONE, main←skid, skid←NOP_VALUE. No accept is possible because in_ready=0.
  - FULL, ~advance: hold.
- Stall=1 with flush=0: advance=0. Held payload and out_valid stay unchanged. One more beat can still be accepted into skid if the state was ONE.
- Latency: in_data appears on out_data 1 cycle after acceptance when empty. A skidded beat appears 1 cycle after the advance that drains main.
- Ordering: strict FIFO, no duplication, no loss except by flush or reset.
- out_data is NOP_VALUE whenever out_valid=0. Downstream may decode it unguarded as a bubble.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, in_data=0xAA → out_valid=0, out_data=0, in_ready=1, occupancy=0, flush_cnt=0 at release.
- Streaming: out_ready=1 and in_data=1,2,3,4 on consecutive cycles → out_data=1,2,3,4 on consecutive cycles, each 1 cycle later; occupancy stays 1; in_ready stays 1.
- Backpressure/skid: send 5,6,7 with out_ready=0 → occupancy 1 then 2, in_ready=0 after the 6 is accepted, 7 is held upstream. Release out_ready → outputs 5,6,7 in order, no loss.
- Stall vs flush: occupancy=2 holding 8,9, assert stall=1 and flush=1 in the same cycle → next cycle out_valid=0, out_data=NOP_VALUE, occupancy=0, flush_cnt=1; the in_data presented that cycle never appears at the output.
- Stall hold: occupancy=1 holding 0x10, stall=1 with out_ready=1 for 3 cycles → out_data stays 0x10 and out_valid stays 1; drains on the first cycle with stall=0.
- Counter: CNT_W=2, apply 5 flush pulses → flush_cnt=1,2,3,3,3. Then cnt_clr=1 together with flush=1 → flush_cnt=0.
